// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: FSM states, port select and latency bounds.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter, master = pipeline/memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ext;
  logic          if_done;
  logic [31:0]   if_instr;
  logic          if_busy;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          dm_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_ext, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_instr, if_busy, dm_done, dm_rdata, dm_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_ext, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_instr, if_busy, dm_done, dm_rdata, dm_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter: load at issue, cap pulses on the MEM_LAT-th enabled cycle.
module mem_lat_counter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic cap
);

  localparam int LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT_C);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAT_V;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cap = en && (cnt == LAT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: write done t+1, read t+MEM_LAT+1, extended fetch t+2*MEM_LAT+2.
// Requesters stall on if_busy/dm_busy; data wins ties unless MEM_ARBITER_STARVE_GUARD_EN forces fetch.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 16,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t        state_q, state_d;
  port_t         sel_q;
  logic [AW-1:0] addr_q;
  logic          ext_q;
  logic          word_q;
  logic          reissue_q;
  logic [DW-1:0] lo_q;
  logic [31:0]   if_instr_q;
  logic [DW-1:0] dm_rdata_q;

  logic grant_if, grant_dm, reissue, issue, cap, starve_hit;
  logic if_go, dm_go;

  // Gating with rst keeps every combinational output at 0 while reset is held.
  assign if_go = rst && bus.if_req;
  assign dm_go = rst && bus.dm_req;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    reissue  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_go && !(if_go && starve_hit)) begin
          grant_dm = 1'b1;
          state_d  = bus.dm_wr ? RESP : WAIT;
        end else if (if_go) begin
          grant_if = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (reissue_q) begin
          reissue = 1'b1;
        end else if (cap && !(sel_q == PORT_IF && ext_q && !word_q)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue = grant_if || grant_dm || reissue;

  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (issue),
    .en   (state_q == WAIT && !reissue_q),
    .cap  (cap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= PORT_IF;
      addr_q     <= '0;
      ext_q      <= 1'b0;
      word_q     <= 1'b0;
      reissue_q  <= 1'b0;
      lo_q       <= '0;
      if_instr_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_dm) begin
        sel_q <= PORT_DM;
      end
      if (grant_if) begin
        sel_q  <= PORT_IF;
        addr_q <= bus.if_addr;
        ext_q  <= bus.if_ext;
        word_q <= 1'b0;
      end
      if (reissue) begin
        reissue_q <= 1'b0;
        word_q    <= 1'b1;
      end
      if (cap) begin
        if (sel_q == PORT_DM) begin
          dm_rdata_q <= bus.mem_rdata;
        end else if (ext_q && !word_q) begin
          // Low word parks in lo_q so if_instr holds the previous instruction until done.
          lo_q      <= bus.mem_rdata;
          reissue_q <= 1'b1;
        end else if (word_q) begin
          if_instr_q <= 32'({bus.mem_rdata, lo_q});
        end else begin
          if_instr_q <= 32'(bus.mem_rdata);
        end
      end
    end
  end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_dm && bus.if_req && starve_q < SW'(STARVE_LIMIT)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign starve_hit = (starve_q >= SW'(STARVE_LIMIT));
`else
  // Strict data priority: the limit can never be reached.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  assign bus.mem_en    = issue;
  assign bus.mem_we    = grant_dm && bus.dm_wr;
  assign bus.mem_wdata = grant_dm ? bus.dm_wdata : '0;
  assign bus.mem_addr  = grant_dm ? bus.dm_addr :
                         grant_if ? bus.if_addr :
                         reissue  ? addr_q + AW'(1) : '0;

  assign bus.if_done  = (state_q == RESP) && (sel_q == PORT_IF);
  assign bus.dm_done  = (state_q == RESP) && (sel_q == PORT_DM);
  assign bus.if_busy  = if_go && !bus.if_done;
  assign bus.dm_busy  = dm_go && !bus.dm_done;
  assign bus.if_instr = if_instr_q;
  assign bus.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT = 2 and a 2-stage memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if #(.AW(32), .DW(16)) bus ();

  mem_arbiter #(.AW(32), .DW(16), .MEM_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem  [0:255];
  logic [15:0] pipe [0:1];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      pipe[0] <= mem[bus.mem_addr[7:0]];
    end
    pipe[1] <= pipe[0];
  end
  assign bus.mem_rdata = pipe[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},    32'(bus.mem_en),   32'd0);
    check({tag, "_we"},    32'(bus.mem_we),   32'd0);
    check({tag, "_addr"},  bus.mem_addr,      32'd0);
    check({tag, "_ifd"},   32'(bus.if_done),  32'd0);
    check({tag, "_dmd"},   32'(bus.dm_done),  32'd0);
    check({tag, "_ifb"},   32'(bus.if_busy),  32'd0);
    check({tag, "_dmb"},   32'(bus.dm_busy),  32'd0);
    check({tag, "_instr"}, bus.if_instr,      32'd0);
    check({tag, "_rdata"}, 32'(bus.dm_rdata), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'hBEEF;
    mem[8'h21] = 16'hCAFE;
    mem[8'hFF] = 16'h5A5A;
    mem[8'h00] = 16'hA5A5;
    pipe[0] = '0;
    pipe[1] = '0;
    bus.if_req = 0; bus.if_addr = '0; bus.if_ext = 0;
    bus.dm_req = 0; bus.dm_wr = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst = 1;
    tick();

    // Single-word fetch at 0x10.
    bus.if_req = 1; bus.if_addr = 32'h10; bus.if_ext = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("f1_en_c%0d", c),   32'(bus.mem_en),  32'(c == 1));
      check($sformatf("f1_done_c%0d", c), 32'(bus.if_done), 32'(c == 4));
      check($sformatf("f1_busy_c%0d", c), 32'(bus.if_busy), 32'(c != 4));
      if (c == 1) check("f1_addr", bus.mem_addr, 32'h10);
      if (c == 4) check("f1_instr", bus.if_instr, 32'h0000_1234);
      tick();
    end
    bus.if_req = 0;
    @(negedge clk);
    check("f1_after_en", 32'(bus.mem_en), 32'd0);
    tick();

    // Extended fetch at 0x20.
    bus.if_req = 1; bus.if_addr = 32'h20; bus.if_ext = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("f2_en_c%0d", c),   32'(bus.mem_en),  32'(c == 1 || c == 4));
      check($sformatf("f2_done_c%0d", c), 32'(bus.if_done), 32'(c == 7));
      if (c == 1) check("f2_addr_lo", bus.mem_addr, 32'h20);
      if (c == 4) check("f2_addr_hi", bus.mem_addr, 32'h21);
      if (c == 6) check("f2_instr_held", bus.if_instr, 32'h0000_1234);
      if (c == 7) check("f2_instr", bus.if_instr, 32'hCAFE_BEEF);
      tick();
    end
    bus.if_req = 0; bus.if_ext = 0;
    tick();

    // Data write 0x40 <= 0x00AA, then read it back.
    bus.dm_req = 1; bus.dm_wr = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 16'h00AA;
    @(negedge clk);
    check("wr_en", 32'(bus.mem_en), 32'd1);
    check("wr_we", 32'(bus.mem_we), 32'd1);
    check("wr_addr", bus.mem_addr, 32'h40);
    check("wr_wdata", 32'(bus.mem_wdata), 32'h00AA);
    check("wr_busy", 32'(bus.dm_busy), 32'd1);
    tick();
    @(negedge clk);
    check("wr_done", 32'(bus.dm_done), 32'd1);
    check("wr_en2", 32'(bus.mem_en), 32'd0);
    tick();
    bus.dm_req = 0; bus.dm_wr = 0;
    tick();
    bus.dm_req = 1; bus.dm_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rd_en_c%0d", c),   32'(bus.mem_en),  32'(c == 1));
      check($sformatf("rd_done_c%0d", c), 32'(bus.dm_done), 32'(c == 4));
      if (c == 4) check("rd_rdata", 32'(bus.dm_rdata), 32'h00AA);
      tick();
    end
    bus.dm_req = 0;
    tick();

    // Simultaneous requests: data first, fetch in the cycle after dm_done.
    bus.dm_req = 1; bus.dm_wr = 0; bus.dm_addr = 32'h40;
    bus.if_req = 1; bus.if_addr = 32'h10; bus.if_ext = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("tie_en_c%0d", c),  32'(bus.mem_en),  32'(c == 1 || c == 5));
      check($sformatf("tie_dmd_c%0d", c), 32'(bus.dm_done), 32'(c == 4));
      check($sformatf("tie_ifd_c%0d", c), 32'(bus.if_done), 32'(c == 8));
      if (c == 1) check("tie_addr_dm", bus.mem_addr, 32'h40);
      if (c == 5) check("tie_addr_if", bus.mem_addr, 32'h10);
      if (c == 8) check("tie_rdata_held", 32'(bus.dm_rdata), 32'h00AA);
      if (c == 8) check("tie_instr", bus.if_instr, 32'h0000_1234);
      tick();
      if (c == 4) bus.dm_req = 0;
    end
    bus.if_req = 0;
    tick();

    // Extended fetch wrapping past the top of the address space.
    bus.if_req = 1; bus.if_addr = 32'hFFFF_FFFF; bus.if_ext = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 4) check("wrap_addr_hi", bus.mem_addr, 32'h0000_0000);
      if (c == 7) check("wrap_instr", bus.if_instr, 32'hA5A5_5A5A);
      tick();
    end
    bus.if_req = 0; bus.if_ext = 0;
    tick();

    // Reset in the middle of an extended fetch; held if_req restarts from the low word.
    bus.if_req = 1; bus.if_addr = 32'h20; bus.if_ext = 1;
    tick();
    tick();
    rst = 0;
    #1;
    check_idle_outputs("mid_rst");
    tick();
    @(negedge clk);
    check("rst_hold_done", 32'(bus.if_done), 32'd0);
    check("rst_hold_en", 32'(bus.mem_en), 32'd0);
    tick();
    rst = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("rr_en_c%0d", c),   32'(bus.mem_en),  32'(c == 1 || c == 4));
      check($sformatf("rr_done_c%0d", c), 32'(bus.if_done), 32'(c == 7));
      if (c == 1) check("rr_addr_lo", bus.mem_addr, 32'h20);
      if (c == 7) check("rr_instr", bus.if_instr, 32'hCAFE_BEEF);
      tick();
    end
    bus.if_req = 0; bus.if_ext = 0;
    tick();

    // Continuous data writes against a pending fetch.
    bus.dm_req = 1; bus.dm_wr = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 16'h0011;
    bus.if_req = 1; bus.if_addr = 32'h10; bus.if_ext = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("stv_en_c%0d", c), 32'(bus.mem_en), 32'(c % 2 == 1));
      if (c % 2 == 0) check($sformatf("stv_dmd_c%0d", c), 32'(bus.dm_done), 32'd1);
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      if (c % 2 == 1) check($sformatf("stv_we_c%0d", c), 32'(bus.mem_we), 32'(c != 9));
      if (c == 9) check("stv_fetch_addr", bus.mem_addr, 32'h10);
`else
      if (c % 2 == 1) check($sformatf("stv_we_c%0d", c), 32'(bus.mem_we), 32'd1);
      if (c == 9) check("stv_data_addr", bus.mem_addr, 32'h80);
`endif
      tick();
    end
    bus.dm_req = 0; bus.dm_wr = 0; bus.if_req = 0;
    rst = 0;
    tick();
    rst = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
